// File: rtl/uart_tx_resposta.sv
// UART transmitter for the sensor response: sends a latched command byte then a
// value byte as two back-to-back 8N1 frames, with busy/done/overrun status.
module uart_tx_resposta #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] command_in,
    input  logic [7:0] value_in,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int BW           = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_next;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic          byte_idx;
    logic [7:0]    shreg, hold;
    logic          bit_end, accept;

    assign bit_end = (baud_cnt == BAUD_LAST);
    // The done cycle still counts as busy so a send landing on it is dropped.
    assign accept  = send && (state == IDLE) && !done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        tx         = 1'b1;
        case (state)
            IDLE:  if (accept) state_next = START;
            START: begin
                tx = 1'b0;
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                tx = shreg[bit_idx];
                if (bit_end && bit_idx == 3'd7) state_next = STOP;
            end
            STOP:  if (bit_end) state_next = byte_idx ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= 1'b0;
            shreg    <= 8'h00;
            hold     <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (send && !accept) overrun <= 1'b1;

            if (state == IDLE || state_next != state || bit_end) baud_cnt <= '0;
            else                                                 baud_cnt <= baud_cnt + 1'b1;

            case (state)
                IDLE: if (accept) begin
                    shreg    <= command_in;
                    hold     <= value_in;
                    byte_idx <= 1'b0;
                    bit_idx  <= '0;
                    busy     <= 1'b1;
                end
                START: if (bit_end) bit_idx <= '0;
                DATA:  if (bit_end) bit_idx <= bit_idx + 3'd1;
                STOP: if (bit_end) begin
                    if (!byte_idx) begin
                        shreg    <= hold;
                        byte_idx <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_resposta.sv
// Directed bench for uart_tx_resposta at 16 clocks per bit: bit-centre sampling
// of both frames, done timing, overrun, async reset and input-change cases.
module tb_uart_tx_resposta;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       send = 1'b0;
    logic [7:0] command_in = 8'h00;
    logic [7:0] value_in = 8'h00;
    logic       tx, busy, done, overrun;

    int checks = 0;
    int errors = 0;

    uart_tx_resposta #(.CLK_FREQ(16), .BAUD_RATE(1)) dut (
        .clock(clock), .reset(reset), .send(send),
        .command_in(command_in), .value_in(value_in),
        .tx(tx), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Line bits in transmit order, bit 0 = command start bit.
    function automatic logic [19:0] frames(input logic [7:0] c, input logic [7:0] v);
        return {1'b1, v, 1'b0, 1'b1, c, 1'b0};
    endfunction

    // Pulse send for one edge; returns in the first start-bit cycle.
    task automatic send_pulse(input logic [7:0] c, input logic [7:0] v);
        command_in = c;
        value_in   = v;
        send       = 1'b1;
        step();
        send = 1'b0;
    endtask

    // Walks cycles 0..320 of a transfer; returns at cycle 321. A send is pulsed
    // in cycle inj, and the inputs are scrambled in cycle 1.
    task automatic run_xfer(input logic [7:0] c, input logic [7:0] v, input int inj, input string tag);
        logic [19:0] exp;
        exp = frames(c, v);
        for (int cyc = 0; cyc <= 320; cyc++) begin
            if (cyc == 0) begin
                chk({tag, " start latency"}, tx, 1'b0);
                chk({tag, " busy at start"}, busy, 1'b1);
            end
            if (cyc < 320 && cyc % 16 == 8)
                chk($sformatf("%s bit%0d", tag, cyc / 16), tx, exp[cyc / 16]);
            if (cyc == 319) chk({tag, " done early"}, {busy, done}, 2'b10);
            if (cyc == 320) chk({tag, " done pulse"}, {busy, done, tx}, 3'b011);
            if (cyc == 1) begin
                command_in = 8'hFF;
                value_in   = 8'hFF;
            end
            send = (cyc == inj);
            step();
        end
        send = 1'b0;
        chk({tag, " done one cycle"}, done, 1'b0);
    endtask

    initial begin
        #2;
        chk("reset state", {tx, busy, done, overrun}, 4'b1000);
        step();
        reset = 1'b0;

        // 1: idle
        for (int i = 0; i < 100; i++) begin
            step();
            chk("idle", {tx, busy, done, overrun}, 4'b1000);
        end

        // 2: basic transfer
        send_pulse(8'h09, 8'h1A);
        run_xfer(8'h09, 8'h1A, -1, "s2");
        chk("s2 overrun", overrun, 1'b0);
        step();
        chk("s2 idle after", {tx, busy, done}, 3'b100);

        // 3: inputs change after acceptance
        send_pulse(8'h08, 8'h37);
        run_xfer(8'h08, 8'h37, -1, "s3");
        chk("s3 overrun", overrun, 1'b0);

        // 4: send while busy
        step();
        send_pulse(8'h09, 8'h1A);
        run_xfer(8'h09, 8'h1A, 100, "s4");
        chk("s4 overrun", overrun, 1'b1);
        repeat (20) step();
        chk("s4 overrun sticky", overrun, 1'b1);

        // 5: async reset mid-DATA
        send_pulse(8'h3B, 8'h00);
        repeat (50) step();
        chk("s5 tx before reset", {tx, busy}, 2'b01);
        reset = 1'b1;
        #1;
        chk("s5 async reset", {tx, busy, done, overrun}, 4'b1000);
        step();
        step();
        reset = 1'b0;
        chk("s5 after release", {tx, busy, overrun}, 3'b100);
        step();
        send_pulse(8'h07, 8'h07);
        run_xfer(8'h07, 8'h07, -1, "s5");
        chk("s5 overrun", overrun, 1'b0);

        // 6: send on done dropped, send the cycle after accepted
        step();
        send_pulse(8'h45, 8'hFF);
        run_xfer(8'h45, 8'hFF, 320, "s6a");
        chk("s6 overrun", overrun, 1'b1);
        send_pulse(8'hAA, 8'hAA);
        run_xfer(8'hAA, 8'hAA, -1, "s6b");
        chk("s6 overrun kept", overrun, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
